// File: rtl/config_saver.sv
// Autosave of the live video settings byte to the SRAM config location.
// It borrows the SRAM bus from the core, writes the byte, then reads it back to verify it.
//
// state   | meaning
// IDLE    | transparent passthrough, waiting for a settings change
// REQ     | hold_req raised, waiting for the core's grant
// SETUP   | address and data driven, strobes inactive
// WRITE   | write strobe low for WE_CYCLES clocks
// RECOVER | write strobe released, data still driven
// READ    | output enable low for RD_CYCLES clocks, capture on the last one
// CHECK   | compare the read-back byte, then retry or finish
// DONE    | verified: update last_saved, pulse save_done
// ERR     | retries exhausted: set save_err, give up on this value
module config_saver #(
  parameter logic [19:0] CFG_ADDR  = 20'h08FD5,
  parameter int          WE_CYCLES = 4,
  parameter int          RD_CYCLES = 2,
  parameter int          MAX_RETRY = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pwon_reset,
  input  logic        save_en,
  input  logic        vga_on,
  input  logic        scanlines_off,
  output logic        hold_req,
  input  logic        hold_ack,
  input  logic [20:0] core_addr_in,
  input  logic        core_we_n_in,
  input  logic        core_oe_n_in,
  input  logic [7:0]  core_data_in,
  output logic [20:0] sram_addr_out,
  output logic        sram_we_n_out,
  output logic        sram_oe_n_out,
  output logic [7:0]  sram_data_out,
  input  logic [7:0]  sram_data_from_chip,
  output logic        busy,
  output logic        save_done,
  output logic        save_err
);

  typedef enum logic [3:0] {
    IDLE, REQ, SETUP, WRITE, RECOVER, READ, CHECK, DONE, ERR
  } state_t;

  localparam logic [3:0] WE_LOAD   = 4'(WE_CYCLES - 1);
  localparam logic [3:0] RD_LOAD   = 4'(RD_CYCLES - 1);
  localparam logic [3:0] RETRY_LIM = 4'(MAX_RETRY);

  state_t      state;
  logic [3:0]  cnt;
  logic [2:0]  retry;
  logic        armed;
  logic [7:0]  last_saved;
  logic [7:0]  wr_byte;
  logic [7:0]  rd_byte;
  logic [7:0]  cfg;
  logic        dirty;
  logic        on_bus;
  logic        owning;

  assign cfg    = {6'b0, ~scanlines_off, vga_on};
  assign dirty  = armed & save_en & ~pwon_reset & (cfg != last_saved);
  assign on_bus = (state == SETUP) || (state == WRITE) || (state == RECOVER) ||
                  (state == READ)  || (state == CHECK);
  assign owning = hold_ack & on_bus;
  assign busy   = (state != IDLE);

  // Passthrough is combinational so a withdrawn grant hands the bus back immediately.
  always_comb begin
    sram_addr_out = core_addr_in;
    sram_we_n_out = core_we_n_in;
    sram_oe_n_out = core_oe_n_in;
    sram_data_out = core_data_in;
    if (owning) begin
      sram_addr_out = {1'b0, CFG_ADDR};
      sram_we_n_out = (state != WRITE);
      sram_oe_n_out = (state != READ);
      sram_data_out = wr_byte;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      retry      <= 3'd0;
      armed      <= 1'b0;
      last_saved <= 8'd0;
      wr_byte    <= 8'd0;
      rd_byte    <= 8'd0;
      hold_req   <= 1'b0;
      save_done  <= 1'b0;
      save_err   <= 1'b0;
    end else begin
      save_done <= 1'b0;
      // Arming snapshots the value the power-on read just restored, so nothing is saved at boot.
      if (!armed && !pwon_reset) begin
        armed      <= 1'b1;
        last_saved <= cfg;
      end
      case (state)
        IDLE: begin
          hold_req <= 1'b0;
          if (dirty) state <= REQ;
        end
        REQ: begin
          hold_req <= 1'b1;
          if (hold_ack) begin
            wr_byte <= cfg;
            state   <= SETUP;
          end
        end
        SETUP, WRITE, RECOVER, READ, CHECK: begin
          hold_req <= 1'b1;
          if (!hold_ack) begin
            state <= REQ;
          end else begin
            case (state)
              SETUP: begin
                cnt   <= WE_LOAD;
                state <= WRITE;
              end
              WRITE: begin
                if (cnt == 4'd0) state <= RECOVER;
                else cnt <= cnt - 4'd1;
              end
              RECOVER: begin
                cnt   <= RD_LOAD;
                state <= READ;
              end
              READ: begin
                if (cnt == 4'd0) begin
                  rd_byte <= sram_data_from_chip;
                  state   <= CHECK;
                end else begin
                  cnt <= cnt - 4'd1;
                end
              end
              CHECK: begin
                if (rd_byte == wr_byte) begin
                  state <= DONE;
                end else begin
                  retry <= retry + 3'd1;
                  if (({1'b0, retry} + 4'd1) < RETRY_LIM) state <= SETUP;
                  else state <= ERR;
                end
              end
              default: ;
            endcase
          end
        end
        DONE: begin
          hold_req   <= 1'b0;
          save_done  <= 1'b1;
          save_err   <= 1'b0;
          retry      <= 3'd0;
          last_saved <= wr_byte;
          state      <= IDLE;
        end
        ERR: begin
          hold_req   <= 1'b0;
          save_err   <= 1'b1;
          retry      <= 3'd0;
          last_saved <= wr_byte;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_config_saver.sv
// Self-checking bench for config_saver: directed steps plus randomized settings
// against a last-saved-value reference model and an SRAM byte model.
module tb_config_saver;

  localparam logic [20:0] CFG_FULL = 21'h008FD5;
  localparam int WE = 4;
  localparam int RD = 2;
  localparam int SAVE_LAT = 1 + WE + 1 + RD + 1 + 1;

  logic        clk = 1'b0;
  logic        rst, pwon_reset, save_en, vga_on, scanlines_off;
  logic        hold_req, hold_ack;
  logic [20:0] core_addr_in;
  logic        core_we_n_in, core_oe_n_in;
  logic [7:0]  core_data_in;
  logic [20:0] sram_addr_out;
  logic        sram_we_n_out, sram_oe_n_out;
  logic [7:0]  sram_data_out, sram_data_from_chip;
  logic        busy, save_done, save_err;

  logic        ack_auto, ack_manual, force_bad;
  logic [7:0]  mem_byte = 8'h00;

  int n_tests = 0;
  int n_fail  = 0;

  // SRAM-side monitor state
  int          n_strobes = 0;
  int          we_w = 0;
  int          last_width = 0;
  int          unstable = 0;
  logic [20:0] st_addr = '0;
  logic [7:0]  st_data = '0;
  logic [7:0]  wr_q[$];
  logic [20:0] wr_addr_q[$];

  logic [7:0]  model_last;

  assign hold_ack = ack_auto ? hold_req : ack_manual;
  assign sram_data_from_chip = force_bad ? 8'hFF : mem_byte;

  always #5 clk = ~clk;

  config_saver dut (
    .clk(clk), .rst(rst), .pwon_reset(pwon_reset), .save_en(save_en),
    .vga_on(vga_on), .scanlines_off(scanlines_off),
    .hold_req(hold_req), .hold_ack(hold_ack),
    .core_addr_in(core_addr_in), .core_we_n_in(core_we_n_in),
    .core_oe_n_in(core_oe_n_in), .core_data_in(core_data_in),
    .sram_addr_out(sram_addr_out), .sram_we_n_out(sram_we_n_out),
    .sram_oe_n_out(sram_oe_n_out), .sram_data_out(sram_data_out),
    .sram_data_from_chip(sram_data_from_chip),
    .busy(busy), .save_done(save_done), .save_err(save_err)
  );

  always @(posedge clk) begin
    if (!sram_we_n_out) begin
      we_w <= we_w + 1;
      if (we_w == 0) begin
        st_addr <= sram_addr_out;
        st_data <= sram_data_out;
      end else if (sram_addr_out != st_addr || sram_data_out != st_data) begin
        unstable <= unstable + 1;
      end
      if (hold_ack && sram_addr_out == CFG_FULL) mem_byte <= sram_data_out;
    end else if (we_w != 0) begin
      we_w       <= 0;
      last_width <= we_w;
      n_strobes  <= n_strobes + 1;
      wr_q.push_back(st_data);
      wr_addr_q.push_back(st_addr);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic sig_val(input int id);
    case (id)
      0: return hold_req;
      1: return save_done;
      2: return save_err;
      3: return !sram_we_n_out && hold_ack;
      4: return !sram_oe_n_out && hold_ack;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_sig(input string tag, input int id, input int budget, output int cyc);
    logic seen;
    seen = 1'b0;
    cyc  = 0;
    while (!seen && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (sig_val(id)) seen = 1'b1;
    end
    check({tag, "_seen"}, 32'(seen), 32'd1);
  endtask

  task automatic quiet(input string tag, input int cycles);
    logic any;
    any = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (hold_req) any = 1'b1;
    end
    check(tag, 32'(any), 32'd0);
  endtask

  // Setting change was applied on the current negedge with auto grant.
  task automatic do_save(input string tag, input logic [7:0] exp);
    int c;
    int s0;
    int u0;
    s0 = n_strobes;
    u0 = unstable;
    wait_sig({tag, "_req"}, 0, 6, c);
    check({tag, "_req_lat"}, 32'(c), 32'd2);
    @(negedge clk);
    wait_sig({tag, "_done"}, 1, 40, c);
    check({tag, "_done_lat"}, 32'(c), 32'(SAVE_LAT));
    check({tag, "_hreq_low"}, 32'(hold_req), 32'd0);
    check({tag, "_err"}, 32'(save_err), 32'd0);
    check({tag, "_nstrobe"}, 32'(n_strobes - s0), 32'd1);
    check({tag, "_width"}, 32'(last_width), 32'(WE));
    check({tag, "_data"}, 32'(wr_q[$]), 32'(exp));
    check({tag, "_addr"}, 32'(wr_addr_q[$]), 32'(CFG_FULL));
    check({tag, "_stable"}, 32'(unstable - u0), 32'd0);
  endtask

  initial begin
    int c;
    int s0;
    logic saw;
    logic v, s, en;
    logic [7:0] cfg_exp;

    rst = 1'b1; pwon_reset = 1'b1; save_en = 1'b1;
    vga_on = 1'b1; scanlines_off = 1'b0;
    ack_auto = 1'b1; ack_manual = 1'b0; force_bad = 1'b0;
    core_addr_in = 21'h12345; core_we_n_in = 1'b1; core_oe_n_in = 1'b1; core_data_in = 8'h5A;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_hold_req", 32'(hold_req), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(save_done), 32'd0);
    check("rst_err", 32'(save_err), 32'd0);
    check("rst_pass_addr", 32'(sram_addr_out), 32'(core_addr_in));
    rst = 1'b0;

    // Power-on: no save while the config read runs or after arming
    quiet("pwon_no_req", 32);
    pwon_reset = 1'b0;
    quiet("armed_no_req", 20);
    model_last = 8'h03;

    // Toggle save: vga 1 -> 0
    @(negedge clk); vga_on = 1'b0;
    do_save("toggle", 8'h02);
    model_last = 8'h02;
    quiet("toggle_settled", 10);

    // Passthrough while idle
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      core_addr_in = 21'($urandom);
      core_we_n_in = 1'($urandom);
      core_oe_n_in = 1'($urandom);
      core_data_in = 8'($urandom);
      #1;
      check("pass_addr", 32'(sram_addr_out), 32'(core_addr_in));
      check("pass_we", 32'(sram_we_n_out), 32'(core_we_n_in));
      check("pass_oe", 32'(sram_oe_n_out), 32'(core_oe_n_in));
      check("pass_data", 32'(sram_data_out), 32'(core_data_in));
      check("pass_busy", 32'(busy), 32'd0);
    end
    @(negedge clk);
    core_we_n_in = 1'b1; core_oe_n_in = 1'b1; core_addr_in = 21'h1ABCDE;

    // Verify failure: read-back forced to FF
    force_bad = 1'b1;
    s0 = n_strobes;
    saw = 1'b0;
    @(negedge clk); vga_on = 1'b1;
    c = 0;
    while (!save_err && c < 80) begin
      @(negedge clk);
      c++;
      if (save_done) saw = 1'b1;
    end
    check("vf_err_set", 32'(save_err), 32'd1);
    check("vf_no_done", 32'(saw), 32'd0);
    check("vf_nstrobe", 32'(n_strobes - s0), 32'd3);
    check("vf_hreq_low", 32'(hold_req), 32'd0);
    quiet("vf_no_retry", 30);
    check("vf_nstrobe_after", 32'(n_strobes - s0), 32'd3);
    force_bad = 1'b0;
    model_last = 8'h03;

    // Grant loss during WRITE
    ack_auto = 1'b0; ack_manual = 1'b0;
    s0 = n_strobes;
    @(negedge clk); scanlines_off = 1'b1;
    wait_sig("gl_req", 0, 6, c);
    ack_manual = 1'b1;
    wait_sig("gl_write", 3, 10, c);
    @(negedge clk);
    ack_manual = 1'b0;
    #1;
    check("gl_pass_we", 32'(sram_we_n_out), 32'(core_we_n_in));
    check("gl_pass_addr", 32'(sram_addr_out), 32'(core_addr_in));
    saw = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (!hold_req || !sram_we_n_out) saw = 1'b1;
    end
    check("gl_hreq_held", 32'(saw), 32'd0);
    check("gl_busy", 32'(busy), 32'd1);
    ack_manual = 1'b1;
    @(negedge clk);
    wait_sig("gl_done", 1, 40, c);
    check("gl_restart_lat", 32'(c), 32'(SAVE_LAT));
    check("gl_nstrobe", 32'(n_strobes - s0), 32'd2);
    check("gl_width", 32'(last_width), 32'(WE));
    check("gl_data", 32'(wr_q[$]), 32'h01);
    check("gl_err_cleared", 32'(save_err), 32'd0);
    ack_auto = 1'b1;
    model_last = 8'h01;
    quiet("gl_settled", 8);

    // Setting change during a save: old byte completes, new byte follows
    @(negedge clk); vga_on = 1'b0;
    wait_sig("mid_write", 3, 12, c);
    scanlines_off = 1'b0;
    wait_sig("mid_done1", 1, 40, c);
    check("mid_data1", 32'(wr_q[$]), 32'h00);
    wait_sig("mid_done2", 1, 40, c);
    check("mid_data2", 32'(wr_q[$]), 32'h02);
    model_last = 8'h02;
    quiet("mid_settled", 8);

    // save_en low blocks starting a save
    @(negedge clk); save_en = 1'b0; vga_on = 1'b1;
    quiet("en_block", 10);
    @(negedge clk); save_en = 1'b1;
    do_save("en_resume", 8'h03);
    model_last = 8'h03;

    // Randomized settings against the last-saved model
    for (int r = 0; r < 12; r++) begin
      v  = 1'($urandom);
      s  = 1'($urandom);
      en = ($urandom_range(0, 3) != 0);
      cfg_exp = {6'b0, ~s, v};
      @(negedge clk);
      vga_on = v; scanlines_off = s; save_en = en;
      if (en && cfg_exp != model_last) begin
        do_save("rnd", cfg_exp);
        model_last = cfg_exp;
      end else begin
        quiet("rnd_idle", 8);
      end
    end
    @(negedge clk); save_en = 1'b1;
    cfg_exp = {6'b0, ~scanlines_off, vga_on};
    if (cfg_exp != model_last) begin
      do_save("rnd_flush", cfg_exp);
      model_last = cfg_exp;
    end

    // Async reset in the middle of READ
    @(negedge clk); vga_on = ~vga_on;
    wait_sig("ar_read", 4, 40, c);
    #2 rst = 1'b1;
    #1;
    check("ar_busy", 32'(busy), 32'd0);
    check("ar_hreq", 32'(hold_req), 32'd0);
    check("ar_done", 32'(save_done), 32'd0);
    check("ar_pass_oe", 32'(sram_oe_n_out), 32'(core_oe_n_in));
    check("ar_pass_addr", 32'(sram_addr_out), 32'(core_addr_in));
    @(negedge clk); rst = 1'b0;
    quiet("ar_rearm_no_req", 10);
    check("ar_err", 32'(save_err), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/config_saver.md
# config_saver

Write-back companion to the power-on video-config read: whenever the live video settings change, this block borrows the SRAM bus from the core and writes the settings byte to the SRAM config location, then reads it back to verify it. It sits between the core's byte-wide SRAM master and the power-on config read stage, whose 21-bit byte-lane address convention it shares (bit 20 = 0 selects the low byte). When idle it is a transparent passthrough.

## Interface
- CFG_ADDR, 20'h08FD5: SRAM word address of the config byte, always written in the low lane.
- WE_CYCLES, 4: width of the write strobe in clocks, 1..15.
- RD_CYCLES, 2: read settle time in clocks, 1..15.
- MAX_RETRY, 3: maximum number of write/verify attempts before reporting an error, 1..7.
- clk  in  1  system clock; the only clock.
- rst  in  1  asynchronous, active-high reset.
- pwon_reset  in  1  power-on read still in progress; the block must not save while this is high.
- save_en  in  1  autosave enable.
- vga_on  in  1  live setting; maps to config bit 0.
- scanlines_off  in  1  live setting; config bit 1 = ~scanlines_off.
- hold_req  out  1  bus request to the core.
- hold_ack  in  1  core grant; the core must be idle while this is high.
- core_addr_in  in  21  core address.
- core_we_n_in, core_oe_n_in  in  1 each  core strobes.
- core_data_in  in  8  core write data.
- sram_addr_out  out  21  to the config read stage.
- sram_we_n_out, sram_oe_n_out  out  1 each  to the config read stage.
- sram_data_out  out  8  to the config read stage.
- sram_data_from_chip  in  8  read data from the config read stage; also returned to the core unchanged.
- busy  out  1  high whenever the state is not IDLE.
- save_done  out  1  one-clock pulse when a verified save completes.
- save_err  out  1  sticky verify failure.

## Operation
- Config byte cfg = {6'b0, ~scanlines_off, vga_on}.
- The block becomes armed on the first clock after rst where pwon_reset = 0. On that clock it loads last_saved <= cfg. No save happens at power-on.
- dirty = armed & save_en & ~pwon_reset & (cfg != last_saved).
- Owning = hold_ack & state in {SETUP, WRITE, RECOVER, READ, CHECK}.
  - While not owning, outputs are combinational passthrough of core_*_in.
  - While owning, sram_addr_out = {1'b0, CFG_ADDR}.
- States and transitions:
  - IDLE: if dirty, go to REQ.
  - REQ: hold_req = 1. On hold_ack = 1, latch wr_byte <= cfg and go to SETUP.
  - SETUP (1 clk): we_n = 1, oe_n = 1, data = wr_byte.
  - WRITE (WE_CYCLES clks): we_n = 0, oe_n = 1, data = wr_byte.
  - RECOVER (1 clk): we_n = 1, data still driven.
  - READ (RD_CYCLES clks): oe_n = 0, we_n = 1. Capture rd_byte <= sram_data_from_chip on the last clock.
  - CHECK (1 clk): if rd_byte == wr_byte, go to DONE. Otherwise increment retry; if retry < MAX_RETRY go to SETUP, else go to ERR.
  - DONE (1 clk): last_saved <= wr_byte, save_done = 1, clear save_err and retry, hold_req = 0. Go to IDLE.
  - ERR (1 clk): last_saved <= wr_byte so the block does not retry forever, save_err <= 1, retry cleared, hold_req = 0. Go to IDLE.
- hold_req stays high from REQ through CHECK.
- If hold_ack drops in SETUP..CHECK: release the bus immediately (passthrough). Go to REQ without incrementing retry; the save restarts at SETUP after the next grant.
- A setting change during a save: wr_byte is not affected. After DONE, dirty re-evaluates and the new value starts another save.
- save_en = 0 only blocks starting a save from IDLE. A save already in progress completes.
- rst mid-operation: state returns to IDLE at once, and all the reset values below apply asynchronously.

## Timing
- Reset values:
  - hold_req = 0, busy = 0, save_done = 0, save_err = 0.
  - armed = 0, retry = 0, last_saved = 0.
  - SRAM outputs in passthrough.
- From cfg changing to hold_req rising: 2 clocks (IDLE → REQ registered).
- With defaults and a continuous grant, hold_ack sampled high → save_done pulse takes 1 + 4 + 1 + 2 + 1 + 1 = 10 clocks. save_done is coincident with hold_req falling.
- The write strobe is exactly WE_CYCLES clocks wide. Address and data are stable from SETUP through RECOVER.
- One failed verify adds 1 + WE_CYCLES + 1 + RD_CYCLES + 1 = 9 clocks (defaults).

## Test plan
- Power-on:
  - Stimulus: rst pulse, pwon_reset high for 32 clocks, vga_on = 1, scanlines_off = 0.
  - Required: armed with last_saved = 8'h03, hold_req never asserted.
- Toggle save:
  - Stimulus: armed, save_en = 1, vga_on 1 → 0, hold_ack follows hold_req.
  - Required: a 4-clock write of 8'h02 at address 21'h008FD5 (lane bit 20 = 0), read-back, save_done 10 clocks after grant, save_err = 0.
- Verify fail:
  - Stimulus: bench forces sram_data_from_chip = 8'hFF on every read.
  - Required: exactly 3 write strobes, then save_err = 1, no save_done, hold_req low, no further attempts.
- Grant loss:
  - Stimulus: hold_ack drops during WRITE.
  - Required: passthrough on the next clock, hold_req stays 1, the save restarts at SETUP on re-grant with retry still 0.
- Passthrough:
  - Stimulus: core read/write traffic while IDLE.
  - Required: sram_*_out equal core_*_in in the same cycle; busy = 0.
- Async reset:
  - Stimulus: rst asserted mid-READ.
  - Required: busy, hold_req and save_done go to 0 without a clock edge; outputs in passthrough.
